fetch_stage: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the main decoder.
- Owns the fetch PC and issues in-order requests to instruction memory over a request/grant and response-valid interface.
- Buffers returned instructions with their PCs and presents them to decode with a valid/ready handshake; decode takes its opcode from id_instr[6:0].
- Handles branch redirects from execute by flushing the buffer and discarding in-flight responses.

---
 rtl/core_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: datapath width, the canonical NOP and the base opcodes
// that fetch and decode both refer to.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head, used both as the instruction
// buffer and as the in-flight PC tag queue. Flush takes priority over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !flush && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues in-order memory requests under a credit
// limit, buffers responses with their PCs for decode, and flushes on redirect.
module fetch_stage
    import core_pkg::*;
#(
    parameter int               XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic              run_q;

    logic [CW-1:0]     inflight;
    logic [XLEN-1:0]   tag_head;
    logic [CW-1:0]     buf_count;
    logic [2*XLEN-1:0] buf_head;

    logic grant, rsp, draining, buf_push, buf_pop, credit;

    // The tag queue holds exactly one PC per outstanding request, so its
    // occupancy doubles as the in-flight counter.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (fetch_pc_q),
        .pop       (rsp),
        .flush     (1'b0),
        .count     (inflight),
        .head      (tag_head)
    );

    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data ({tag_head, imem_rdata}),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head      (buf_head)
    );

    always_comb begin
        credit    = ({1'b0, inflight} + {1'b0, buf_count}) < DEPTH_W;
        imem_req  = run_q && credit && !redirect_valid;
        grant     = imem_req && imem_gnt;
        rsp       = imem_rvalid && (inflight != '0);
        draining  = (discard_q != '0);
        buf_push  = rsp && !draining && !redirect_valid;
        id_valid  = (buf_count != '0);
        buf_pop   = id_valid && id_ready;
        id_instr  = id_valid ? buf_head[XLEN-1:0] : XLEN'(NOP_INSTR);
        id_pc     = id_valid ? buf_head[2*XLEN-1:XLEN] : last_pc_q;
        last_pc_d = id_pc;

        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            discard_d  = inflight - CW'(rsp);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp && draining) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            last_pc_q  <= '0;
            discard_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            last_pc_q  <= last_pc_d;
            discard_q  <= discard_d;
            run_q      <= 1'b1;
        end
    end

    assign imem_addr = fetch_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model plus a PC scoreboard
// checking every instruction decode accepts.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    logic [31:0] mem_q[$];
    bit          mem_en, hold;
    logic [31:0] exp_pc;
    int          n_checks, n_fail, pops, cyc, first_gnt, first_val, pops_mark;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory returns instruction ~addr, in order, one cycle after grant unless held.
    task automatic cycle();
        logic        g;
        logic [31:0] a;
        #1;
        imem_gnt = mem_en;
        if (!hold && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~mem_q.pop_front();
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        g = imem_req && mem_en;
        a = imem_addr;
        if (g && first_gnt < 0) first_gnt = cyc;
        if (id_valid && first_val < 0) first_val = cyc;
        if (id_valid && id_ready && !redirect_valid) begin
            chk("pop_pc", id_pc, exp_pc);
            chk("pop_instr", id_instr, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        @(posedge clk);
        if (g) mem_q.push_back(a);
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        mem_en = 1'b0; hold = 1'b0;
        n_checks = 0; n_fail = 0; pops = 0; cyc = 0;
        first_gnt = -1; first_val = -1;
        exp_pc = 32'h0;

        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);

        // Straight-line fetch with single-cycle memory.
        rst = 1'b0; mem_en = 1'b1; id_ready = 1'b1;
        #1 chk("first_addr", imem_addr, 32'h0);
        repeat (12) cycle();
        chk("grant_to_valid", first_val - first_gnt, 32'd2);
        chk("stream_pops", {31'b0, pops >= 5}, 32'd1);

        // Decode stall: buffer fills, requests stop, head held.
        id_ready = 1'b0;
        repeat (5) cycle();
        #1;
        chk("stall_valid", {31'b0, id_valid}, 32'd1);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_head_pc", id_pc, exp_pc);
        chk("stall_head_instr", id_instr, ~exp_pc);
        repeat (2) begin
            cycle();
            chk("stall_hold_pc", id_pc, exp_pc);
        end
        id_ready = 1'b1;
        repeat (8) cycle();

        // Quiesce, then two requests in flight (0x10, 0x14) redirected to 0x100.
        mem_en = 1'b0;
        repeat (4) cycle();
        chk("drained", {31'b0, id_valid}, 32'd0);
        mem_en = 1'b1; hold = 1'b1; id_ready = 1'b0;
        redirect(32'h10);
        #1 chk("redir_addr_10", imem_addr, 32'h10);
        cycle();
        chk("second_addr", imem_addr, 32'h14);
        cycle();
        #1 chk("two_inflight_req", {31'b0, imem_req}, 32'd0);
        redirect(32'h100);
        hold = 1'b0; id_ready = 1'b1;
        repeat (8) cycle();
        chk("target_seen", {31'b0, exp_pc >= 32'h104}, 32'd1);

        // Unaligned target and address wrap.
        redirect(32'h203);
        #1 chk("align_addr", imem_addr, 32'h200);
        repeat (4) cycle();
        redirect(32'hFFFF_FFFF);
        #1 chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr", imem_addr, 32'h0);
        repeat (6) cycle();

        // Redirect in the same cycle as a response and a decode pop.
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (mem_q.size() > 0 && id_valid) found = 1'b1;
                else cycle();
            end
            chk("rv_pop_found", {31'b0, found}, 32'd1);
        end
        redirect(32'h300);
        #1;
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'h300);
        repeat (6) cycle();

        // Asynchronous reset mid-stream.
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, id_valid}, 32'd0);
        chk("arst_instr", id_instr, 32'h0000_0013);
        chk("arst_pc", id_pc, 32'h0);
        mem_q.delete();
        @(negedge clk);
        rst = 1'b0; exp_pc = 32'h0;
        #1 chk("restart_addr", imem_addr, 32'h0);
        pops_mark = pops;
        repeat (8) cycle();
        chk("restart_pops", {31'b0, pops > pops_mark}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
